// File: rtl/regfile_scoreboard.sv
// Register file with three combinational read ports, ALU and load-return write ports, and a load busy scoreboard.
// Optional same-cycle write bypass on the read ports: define REGFILE_WRITE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_IDX    = 15,
  parameter int LR_IDX    = 14,
  parameter int PC_OFFSET = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] RA3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              BUSY3,
  input  logic [DATA_W-1:0] R15,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] WA_A,
  input  logic [DATA_W-1:0] WD_A,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] WA_B,
  input  logic [DATA_W-1:0] WD_B,
  input  logic              LINK,
  input  logic              LD_ISSUE,
  input  logic [ADDR_W-1:0] LD_DST,
  output logic [ADDR_W:0]   PENDING,
  output logic              ERR_WAW
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);

  logic [DATA_W-1:0] regs     [NREG];
  logic [DATA_W-1:0] regs_nxt [NREG];
  logic [NREG-1:0]   busy, busy_nxt;
  logic [ADDR_W:0]   pending_q, pending_nxt;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] link_val;

  assign link_val = R15 - DATA_W'(PC_OFFSET);

  // Next-state: LINK beats port A, which beats the older load return on port B.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_nxt[i] = regs[i];
      if (ADDR_W'(i) != PC_A) begin
        if (LINK && (ADDR_W'(i) == LR_A))
          regs_nxt[i] = link_val;
        else if (WE_A && (WA_A == ADDR_W'(i)))
          regs_nxt[i] = WD_A;
        else if (WE_B && (WA_B == ADDR_W'(i)))
          regs_nxt[i] = WD_B;
      end
    end

    // Set after clear so a same-edge issue to the returning index stays busy.
    busy_nxt = busy;
    if (WE_B)
      busy_nxt[WA_B] = 1'b0;
    if (LD_ISSUE && (LD_DST != PC_A))
      busy_nxt[LD_DST] = 1'b1;

    err_nxt = err_q;
    if (LD_ISSUE && (LD_DST != PC_A) && busy[LD_DST] && !(WE_B && (WA_B == LD_DST)))
      err_nxt = 1'b1;

    pending_nxt = '0;
    for (int i = 0; i < NREG; i++)
      pending_nxt = pending_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy      <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= regs_nxt[i];
      busy      <= busy_nxt;
      pending_q <= pending_nxt;
      err_q     <= err_nxt;
    end
  end

  assign PENDING = pending_q;
  assign ERR_WAW = err_q;

  logic [ADDR_W-1:0] ra [3];
  logic [DATA_W-1:0] rd [3];
  logic              bz [3];

  assign ra[0] = RA1;
  assign ra[1] = RA2;
  assign ra[2] = RA3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p] = regs[ra[p]];
      bz[p] = busy[ra[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (LINK && (ra[p] == LR_A))
        rd[p] = link_val;
      else if (WE_A && (WA_A == ra[p]))
        rd[p] = WD_A;
      else if (WE_B && (WA_B == ra[p]))
        rd[p] = WD_B;
      // A returning load is about to clear this bit, so the reader need not stall.
      if (WE_B && (WA_B == ra[p]))
        bz[p] = 1'b0;
`endif
      if (ra[p] == PC_A) begin
        rd[p] = R15;
        bz[p] = 1'b0;
      end
    end
  end

  assign RD1   = rd[0];
  assign RD2   = rd[1];
  assign RD3   = rd[2];
  assign BUSY1 = bz[0];
  assign BUSY2 = bz[1];
  assign BUSY3 = bz[2];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: writes, link, scoreboard, WAW error, async reset and bypass.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              CLK, RST;
  logic [ADDR_W-1:0] RA1, RA2, RA3;
  logic [DATA_W-1:0] RD1, RD2, RD3;
  logic              BUSY1, BUSY2, BUSY3;
  logic [DATA_W-1:0] R15;
  logic              WE_A, WE_B, LINK, LD_ISSUE;
  logic [ADDR_W-1:0] WA_A, WA_B, LD_DST;
  logic [DATA_W-1:0] WD_A, WD_B;
  logic [ADDR_W:0]   PENDING;
  logic              ERR_WAW;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(15), .LR_IDX(14), .PC_OFFSET(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .RD1(RD1), .RD2(RD2), .RD3(RD3),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .BUSY3(BUSY3),
    .R15(R15),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .LINK(LINK), .LD_ISSUE(LD_ISSUE), .LD_DST(LD_DST),
    .PENDING(PENDING), .ERR_WAW(ERR_WAW)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    WE_A = 0; WA_A = 0; WD_A = 0;
    WE_B = 0; WA_B = 0; WD_B = 0;
    LINK = 0; LD_ISSUE = 0; LD_DST = 0;
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
    idle();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    R15 = 32'h0;
    RA1 = 0; RA2 = 0; RA3 = 0;
    idle();
    #3;
    chk("rst_rd1", RD1, 0);
    chk("rst_pending", PENDING, 0);
    chk("rst_err", ERR_WAW, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // ALU write, with pre-edge view on RA3
    WE_A = 1; WA_A = 3; WD_A = 32'hDEADBEEF; RA3 = 3;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("pre_edge_rd3", RD3, 32'hDEADBEEF);
`else
    chk("pre_edge_rd3", RD3, 32'h0);
`endif
    step();
    RA1 = 3; RA2 = 15; R15 = 32'h108;
    #1;
    chk("alu_rd1", RD1, 32'hDEADBEEF);
    chk("pc_rd2", RD2, 32'h108);
    chk("pc_busy2", BUSY2, 0);

    // write to PC index is dropped
    WE_A = 1; WA_A = 15; WD_A = 32'hAA;
    step();
    chk("pcw_rd2", RD2, 32'h108);
    chk("pcw_rd1", RD1, 32'hDEADBEEF);

    // LINK beats port A on index 14
    LINK = 1; R15 = 32'h200; WE_A = 1; WA_A = 14; WD_A = 32'h55;
    step();
    RA1 = 14;
    #1;
    chk("link_rd1", RD1, 32'h1FC);

    // port A beats port B on the same index
    WE_A = 1; WA_A = 6; WD_A = 32'hA6; WE_B = 1; WA_B = 6; WD_B = 32'hB6;
    step();
    RA2 = 6;
    #1;
    chk("prio_rd2", RD2, 32'hA6);

    // load scoreboard
    LD_ISSUE = 1; LD_DST = 5;
    step();
    RA1 = 5;
    #1;
    chk("ld_busy1", BUSY1, 1);
    chk("ld_pending", PENDING, 1);
    WE_B = 1; WA_B = 5; WD_B = 32'h1234; LD_ISSUE = 1; LD_DST = 5;
    step();
    chk("setclr_busy1", BUSY1, 1);
    chk("setclr_rd1", RD1, 32'h1234);
    chk("setclr_pending", PENDING, 1);
    chk("setclr_err", ERR_WAW, 0);
    WE_B = 1; WA_B = 5; WD_B = 32'h5678;
    step();
    chk("ret_busy1", BUSY1, 0);
    chk("ret_rd1", RD1, 32'h5678);
    chk("ret_pending", PENDING, 0);

    // WAW error
    LD_ISSUE = 1; LD_DST = 7;
    step();
    chk("waw1_err", ERR_WAW, 0);
    LD_ISSUE = 1; LD_DST = 7;
    step();
    RA2 = 7;
    #1;
    chk("waw2_err", ERR_WAW, 1);
    chk("waw2_pending", PENDING, 1);
    chk("waw2_busy2", BUSY2, 1);
    LD_ISSUE = 1; LD_DST = 15;
    step();
    RA3 = 15;
    #1;
    chk("ldpc_pending", PENDING, 1);
    chk("ldpc_busy3", BUSY3, 0);
    WE_B = 1; WA_B = 7; WD_B = 32'h77;
    step();
    chk("waw_sticky", ERR_WAW, 1);
    chk("waw_ret_pending", PENDING, 0);

    // two loads outstanding, then mid-cycle async reset
    LD_ISSUE = 1; LD_DST = 8;
    step();
    LD_ISSUE = 1; LD_DST = 9;
    step();
    chk("two_pending", PENDING, 2);
    RA1 = 3; RA2 = 8; RA3 = 6;
    #2 RST = 1'b1;
    #1;
    chk("arst_rd1", RD1, 0);
    chk("arst_rd3", RD3, 0);
    chk("arst_busy2", BUSY2, 0);
    chk("arst_pending", PENDING, 0);
    chk("arst_err", ERR_WAW, 0);
    #1 RST = 1'b0;

    // stale load return after reset still writes, busy stays clear
    WE_B = 1; WA_B = 8; WD_B = 32'h88;
    step();
    chk("stale_rd2", RD2, 32'h88);
    chk("stale_busy2", BUSY2, 0);
    chk("stale_pending", PENDING, 0);

    // bypass window on a second write
    RA3 = 2;
    WE_A = 1; WA_A = 2; WD_A = 32'h77;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("byp_rd3", RD3, 32'h77);
`else
    chk("byp_rd3", RD3, 32'h0);
`endif
    step();
    chk("post_rd3", RD3, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core register file: three combinational read ports and two write ports.
- Write port A carries ALU results; write port B carries load returns.
- A per-register busy scoreboard tracks outstanding loads so the hazard unit can stall on them.
- Adds an asynchronous reset, a BL link write, WAW error detection and an optional same-cycle write bypass.
- Sits between decode (reads) and writeback (writes) in the single-issue pipeline.

Parameters:
DATA_W, 32, data width of every register and port
ADDR_W, 4, register address width; NREG = 2**ADDR_W
PC_IDX, 15, index whose read returns the R15 input; never stored
LR_IDX, 14, link register index written on LINK
PC_OFFSET, 4, value subtracted from R15 when forming the link value

Ports:
CLK  input  1  clock; all state updates on the falling edge
RST  input  1  asynchronous active-high reset
RA1  input  ADDR_W  read address, port 1
RA2  input  ADDR_W  read address, port 2
RA3  input  ADDR_W  read address, port 3 (shift-by-register operand)
RD1  output  DATA_W  read data, port 1
RD2  output  DATA_W  read data, port 2
RD3  output  DATA_W  read data, port 3
BUSY1  output  1  register at RA1 has a load outstanding
BUSY2  output  1  register at RA2 has a load outstanding
BUSY3  output  1  register at RA3 has a load outstanding
R15  input  DATA_W  current PC+8 from the datapath
WE_A  input  1  write enable, ALU write port
WA_A  input  ADDR_W  write address, ALU write port
WD_A  input  DATA_W  write data, ALU write port
WE_B  input  1  write enable, load-return write port
WA_B  input  ADDR_W  write address, load-return write port
WD_B  input  DATA_W  write data, load-return write port
LINK  input  1  BL executing; write the link register
LD_ISSUE  input  1  a load is issued this cycle
LD_DST  input  ADDR_W  destination register of the issued load
PENDING  output  ADDR_W+1  number of busy bits currently set
ERR_WAW  output  1  sticky: a load was issued to an already-busy register

Behaviour:
- Reset:
  - RST high asynchronously clears all stored registers, every busy bit, PENDING and ERR_WAW.
  - Outstanding loads are discarded on reset.
  - A WE_B return arriving after reset still writes its data; busy stays 0.
- Reads (combinational):
  - RDn = R15 when RAn == PC_IDX, else reg[RAn].
  - BUSYn = busy[RAn], forced 0 when RAn == PC_IDX.
- Writes occur on the falling edge of CLK, giving write-before-read within one cycle.
- Writes to PC_IDX on either port are ignored.
- Same-edge priority on one index: LINK > port A > port B.
  - LINK writes reg[LR_IDX] = R15 - PC_OFFSET, modulo 2**DATA_W.
  - Port A is the younger instruction, so it overrides a stale load return.
- Scoreboard, on the falling edge:
  - Clear: WE_B clears busy[WA_B].
  - Set: LD_ISSUE with LD_DST != PC_IDX sets busy[LD_DST].
  - Set and clear on the same index in the same edge: set wins and the bit stays busy.
  - A port A write never changes busy.
- PENDING is the population count of busy, updated on the same edge. It ranges 0..NREG-1, with no wrap.
- ERR_WAW sets when LD_ISSUE targets an index that is busy and not being cleared on the same edge. It holds until RST.
- LD_ISSUE to PC_IDX is ignored and does not set ERR_WAW.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - For RAn != PC_IDX, RDn is taken from the same-cycle write sources before the array, in priority order LINK (when RAn == LR_IDX), then WE_A && WA_A == RAn, then WE_B && WA_B == RAn.
  - BUSYn is forced 0 when the bypass matches WE_B.
- Undefined: reads return array contents only; new data becomes visible after the falling edge.

Test Plan:
- Reset: assert RST mid-cycle after writes -> all RDn = 0, BUSYn = 0, PENDING = 0, ERR_WAW = 0, immediately and without waiting for a clock edge.
- ALU write and PC read: WE_A, WA_A=3, WD_A=0xDEADBEEF, one falling edge; then RA1=3, RA2=15, R15=0x108 -> RD1=0xDEADBEEF, RD2=0x108. A WE_A to index 15 changes nothing.
- Link write: LINK=1, R15=0x200, WE_A with WA_A=14, WD_A=0x55 on the same edge -> RD1 at RA1=14 reads 0x1FC.
- Load scoreboard: LD_ISSUE with LD_DST=5 -> BUSY1=1 at RA1=5, PENDING=1. Next edge: WE_B, WA_B=5, WD_B=0x1234 together with LD_ISSUE, LD_DST=5 -> busy remains 1, data reads 0x1234, ERR_WAW=0.
- WAW error: LD_ISSUE to 7 twice without a return -> ERR_WAW=1 and PENDING=1. ERR_WAW stays 1 until RST.
- Bypass, macro defined: WE_A, WA_A=2, WD_A=0x77 with RA3=2, sampled before the falling edge -> RD3=0x77. With the macro undefined, RD3 shows the old value until the falling edge.
